// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges ALU results and FIFO-buffered load returns into the regfile write port; optional perf counters via WB_PERF_COUNTERS_EN.
// Latency: ALU accept -> write next cycle; load accept -> earliest write two cycles later.
// Backpressure: a full load FIFO drops ld_ready and alu_ready and forces its head out.
module writeback_arbiter #(
    parameter int LD_DEPTH = 2,
    parameter int XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [4:0]      ld_rd,
    input  logic [XLEN-1:0] ld_data,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    output logic [31:0]     busy_mask,
    output logic            wr_ena,
    output logic [4:0]      wr_addr,
    output logic [XLEN-1:0] wr_data,
    output logic [31:0]     alu_stall_cnt,
    output logic [31:0]     ld_commit_cnt
);
    localparam int AW = $clog2(LD_DEPTH);
    localparam int CW = $clog2(LD_DEPTH + 1);

    logic [CW-1:0]   r_count;
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [4:0]      r_mem_rd   [LD_DEPTH];
    logic [XLEN-1:0] r_mem_data [LD_DEPTH];
    logic [31:0]     r_busy;
    logic            r_wr_ena;
    logic [4:0]      r_wr_addr;
    logic [XLEN-1:0] r_wr_data;

    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_win;
    logic [4:0]      w_head_rd;
    logic [XLEN-1:0] w_head_data;
    logic [4:0]      w_win_rd;
    logic [XLEN-1:0] w_win_data;
    logic [31:0]     w_set;
    logic [31:0]     w_clr;

    // Ready depends only on the registered count, never on this cycle's pop.
    assign w_full      = (r_count == CW'(LD_DEPTH));
    assign w_empty     = (r_count == '0);
    assign ld_ready    = !w_full;
    assign alu_ready   = !w_full;
    assign w_push      = ld_valid && !w_full;
    assign w_pop       = w_full || (!alu_valid && !w_empty);
    assign w_win       = w_pop || alu_valid;
    assign w_head_rd   = r_mem_rd[r_rptr];
    assign w_head_data = r_mem_data[r_rptr];
    assign w_win_rd    = w_pop ? w_head_rd   : alu_rd;
    assign w_win_data  = w_pop ? w_head_data : alu_data;
    assign w_set       = (issue_valid && issue_rd != 5'd0) ? (32'd1 << issue_rd) : 32'd0;
    assign w_clr       = (w_pop && w_head_rd != 5'd0) ? (32'd1 << w_head_rd) : 32'd0;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_rd[r_wptr]   <= ld_rd;
            r_mem_data[r_wptr] <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count   <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_busy    <= '0;
            r_wr_ena  <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (!w_push && w_pop) r_count <= r_count - CW'(1);
            // Issue set is applied after commit clear so the newer load wins.
            r_busy   <= ((r_busy & ~w_clr) | w_set) & ~32'd1;
            r_wr_ena <= w_win && (w_win_rd != 5'd0);
            if (w_win && w_win_rd != 5'd0) begin
                r_wr_addr <= w_win_rd;
                r_wr_data <= w_win_data;
            end
        end
    end

    assign busy_mask = r_busy;
    assign wr_ena    = r_wr_ena;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;

`ifdef WB_PERF_COUNTERS_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_commit_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt  <= '0;
            r_commit_cnt <= '0;
        end else begin
            if (alu_valid && w_full) r_stall_cnt  <= r_stall_cnt + 32'd1;
            if (w_pop)               r_commit_cnt <= r_commit_cnt + 32'd1;
        end
    end

    assign alu_stall_cnt = r_stall_cnt;
    assign ld_commit_cnt = r_commit_cnt;
`else
    assign alu_stall_cnt = 32'd0;
    assign ld_commit_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_writeback_arbiter.sv
// Randomized plus directed bench for writeback_arbiter; expected writes are queued by a
// transaction-level model and compared by an independent monitor.
module tb_writeback_arbiter;
    localparam int LD_DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, alu_ready, ld_valid, ld_ready, issue_valid, wr_ena;
    logic [4:0]  alu_rd, ld_rd, issue_rd, wr_addr;
    logic [31:0] alu_data, ld_data, wr_data, busy_mask, alu_stall_cnt, ld_commit_cnt;

    writeback_arbiter #(.LD_DEPTH(LD_DEPTH), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .busy_mask(busy_mask),
        .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
        .alu_stall_cnt(alu_stall_cnt), .ld_commit_cnt(ld_commit_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; logic [4:0] rd; logic [31:0] d; } wr_t;
    typedef struct { logic [4:0] rd; logic [31:0] d; } ld_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    wr_t         exp_q[$];
    ld_t         m_q[$];
    logic [31:0] m_busy   = 0;
    logic [31:0] m_stall  = 0;
    logic [31:0] m_commit = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every write the DUT presents must match the oldest expected write.
    initial begin
        forever begin
            @(negedge clk);
            if (wr_ena === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write_addr", {59'd0, wr_addr}, 64'hFFFF);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("write_cycle", 64'(cyc), 64'(e.cyc));
                    chk("write_addr", {59'd0, wr_addr}, {59'd0, e.rd});
                    chk("write_data", {32'd0, wr_data}, {32'd0, e.d});
                end
            end
        end
    end

    // One cycle of stimulus; the model applies the arbitration rules to its own load queue.
    task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                        input logic iv, input logic [4:0] ird);
        bit          full;
        logic [31:0] clr;
        ld_t         e;
        @(negedge clk);
        alu_valid = av; alu_rd = ard; alu_data = ad;
        ld_valid = lv; ld_rd = lrd; ld_data = ld;
        issue_valid = iv; issue_rd = ird;
        #1;
        full = (m_q.size() == LD_DEPTH);
        chk("alu_ready", {63'd0, alu_ready}, {63'd0, !full});
        chk("ld_ready", {63'd0, ld_ready}, {63'd0, !full});
        chk("busy_mask", {32'd0, busy_mask}, {32'd0, m_busy});
`ifdef WB_PERF_COUNTERS_EN
        chk("alu_stall_cnt", {32'd0, alu_stall_cnt}, {32'd0, m_stall});
        chk("ld_commit_cnt", {32'd0, ld_commit_cnt}, {32'd0, m_commit});
`else
        chk("alu_stall_cnt", {32'd0, alu_stall_cnt}, 64'd0);
        chk("ld_commit_cnt", {32'd0, ld_commit_cnt}, 64'd0);
`endif
        clr = 0;
        if (full || (!av && m_q.size() > 0)) begin
            e = m_q.pop_front();
            m_commit++;
            if (e.rd != 0) begin
                exp_q.push_back('{cyc + 1, e.rd, e.d});
                clr[e.rd] = 1'b1;
            end
        end else if (av && ard != 0) begin
            exp_q.push_back('{cyc + 1, ard, ad});
        end
        if (av && full) m_stall++;
        if (lv && !full) m_q.push_back('{lrd, ld});
        m_busy = m_busy & ~clr;
        if (iv && ird != 0) m_busy[ird] = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    logic        r_av, r_lv, r_iv, hold_a, hold_l, full_before;
    logic [4:0]  r_ard, r_lrd, r_ird;
    logic [31:0] r_ad, r_ld;

    initial begin
        rst = 1'b0;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        ld_valid = 0; ld_rd = 0; ld_data = 0;
        issue_valid = 0; issue_rd = 0;
        #1;
        chk("reset_wr_ena", {63'd0, wr_ena}, 64'd0);
        chk("reset_wr_addr", {59'd0, wr_addr}, 64'd0);
        chk("reset_wr_data", {32'd0, wr_data}, 64'd0);
        chk("reset_busy", {32'd0, busy_mask}, 64'd0);
        chk("reset_ld_ready", {63'd0, ld_ready}, 64'd1);
        #11 rst = 1'b1;

        // ALU only
        step(1, 5, 32'h1234, 0, 0, 0, 0, 0);
        idle(2);
        // Load to x7 contending with ALU writes to x3
        step(0, 0, 0, 0, 0, 0, 1, 7);
        step(0, 0, 0, 1, 7, 32'hDEADBEEF, 0, 0);
        step(1, 3, 32'h33, 0, 0, 0, 0, 0);
        step(1, 3, 32'h34, 0, 0, 0, 0, 0);
        idle(3);
        // FIFO full stall with ALU continuously valid
        step(0, 0, 0, 0, 0, 0, 1, 8);
        step(1, 1, 32'hA1, 1, 8, 32'h88, 1, 9);
        step(1, 1, 32'hA2, 1, 9, 32'h99, 0, 0);
        step(1, 1, 32'hA3, 0, 0, 0, 0, 0);
        step(1, 1, 32'hA4, 1, 11, 32'hBB, 0, 0);
        step(1, 1, 32'hA5, 0, 0, 0, 0, 0);
        step(1, 1, 32'hA6, 0, 0, 0, 0, 0);
        idle(3);
        // x0 handling
        step(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0, 32'h5555, 0, 0);
        idle(3);
        // Scoreboard set-wins on x10
        step(0, 0, 0, 0, 0, 0, 1, 10);
        step(0, 0, 0, 1, 10, 32'h1010, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 10);
        idle(3);
        // Async reset with two loads buffered and busy_mask = 0x600
        step(0, 0, 0, 0, 0, 0, 1, 9);
        step(1, 2, 32'h22, 1, 9, 32'h9999, 0, 0);
        step(1, 2, 32'h23, 1, 10, 32'hAAAA, 0, 0);
        @(negedge clk);
        alu_valid = 0; ld_valid = 0; issue_valid = 0;
        #2 rst = 1'b0;
        #1;
        chk("midreset_wr_ena", {63'd0, wr_ena}, 64'd0);
        chk("midreset_busy", {32'd0, busy_mask}, 64'd0);
        chk("midreset_ld_ready", {63'd0, ld_ready}, 64'd1);
        exp_q.delete(); m_q.delete();
        m_busy = 0; m_stall = 0; m_commit = 0;
        @(negedge clk);
        #2 rst = 1'b1;
        idle(4);

        // Randomized traffic; producers hold payload while stalled
        hold_a = 0; hold_l = 0;
        for (int i = 0; i < 1500; i++) begin
            if (!hold_a) begin
                r_av = ($urandom_range(0, 3) != 0);
                r_ard = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                r_ad = $urandom;
            end
            if (!hold_l) begin
                r_lv = ($urandom_range(0, 1) != 0);
                r_lrd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                r_ld = $urandom;
            end
            r_iv = ($urandom_range(0, 2) == 0);
            r_ird = 5'($urandom_range(0, 31));
            full_before = (m_q.size() == LD_DEPTH);
            step(r_av, r_ard, r_ad, r_lv, r_lrd, r_ld, r_iv, r_ird);
            hold_a = r_av && full_before;
            hold_l = r_lv && full_before;
        end
        idle(5);
        @(negedge clk);
        #2;
        chk("writes_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
